// File: rtl/collision_sched_if.sv
// Signal bundle between a frame/obstacle source (master) and collision_sched (slave).
interface collision_sched_if #(
    parameter int NUM_OBST    = 4,
    parameter int VWIDTH      = 12,
    parameter int LWIDTH      = 2,
    parameter int COUNT_WIDTH = 32,
    parameter int START_LIVES = 3
);
    localparam int SLOT_W = $clog2(NUM_OBST);
    localparam int LIFE_W = $clog2(START_LIVES + 1);

    logic                     frame_tick;
    logic                     restart;
    logic [LWIDTH-1:0]        player_lane;
    logic signed [VWIDTH-1:0] player_voffset;
    logic [NUM_OBST-1:0]      obst_valid;
    logic [LWIDTH-1:0]        obst_lane    [NUM_OBST];
    logic signed [VWIDTH-1:0] obst_voffset [NUM_OBST];

    logic                     busy;
    logic                     sweep_done;
    logic                     hit_pulse;
    logic [SLOT_W-1:0]        hit_slot;
    logic [COUNT_WIDTH-1:0]   hit_count;
    logic [LIFE_W-1:0]        lives;
    logic                     game_over;

    modport master (
        output frame_tick, restart, player_lane, player_voffset,
               obst_valid, obst_lane, obst_voffset,
        input  busy, sweep_done, hit_pulse, hit_slot, hit_count, lives, game_over
    );

    modport slave (
        input  frame_tick, restart, player_lane, player_voffset,
               obst_valid, obst_lane, obst_voffset,
        output busy, sweep_done, hit_pulse, hit_slot, hit_count, lives, game_over
    );
endinterface

// File: rtl/collision_sched.sv
// Per-frame obstacle collision sweep with hit counting and lives; one slot per cycle.
// Optional post-hit immunity window is enabled by defining COLLISION_INVULN_EN.
//
// state | meaning
// IDLE  | waiting for frame_tick
// SCAN  | evaluating slot idx through the shared comparator
// DONE  | one-cycle sweep_done, then IDLE or OVER
// OVER  | no lives left; only restart leaves
module collision_sched #(
    parameter int NUM_OBST      = 4,
    parameter int VWIDTH        = 12,
    parameter int LWIDTH        = 2,
    parameter int COUNT_WIDTH   = 32,
    parameter int HIT_WINDOW    = 5,
    parameter int START_LIVES   = 3,
    parameter int INVULN_FRAMES = 60
) (
    input logic               clk,
    input logic               rst_n,
    collision_sched_if.slave  bus
);
    localparam int SLOT_W = $clog2(NUM_OBST);
    localparam int LIFE_W = $clog2(START_LIVES + 1);
    localparam int DW     = VWIDTH + 1;

    if (NUM_OBST < 2 || START_LIVES < 1 || INVULN_FRAMES < 1) begin : g_param_check
        $error("collision_sched: NUM_OBST>=2, START_LIVES>=1, INVULN_FRAMES>=1 required");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE,
        S_OVER
    } state_t;

    state_t state, state_nxt;

    logic [SLOT_W-1:0]        idx;
    logic [LWIDTH-1:0]        snap_lane;
    logic signed [VWIDTH-1:0] snap_voffset;
    logic [NUM_OBST-1:0]      hit_flag;
    logic                     hit_pulse_q;
    logic [SLOT_W-1:0]        hit_slot_q;
    logic [COUNT_WIDTH-1:0]   hit_count_q;
    logic [LIFE_W-1:0]        lives_q;

    logic signed [DW-1:0]     ext_obst;
    logic signed [DW-1:0]     ext_player;
    logic signed [DW-1:0]     delta;
    logic [DW-1:0]            delta_mag;
    logic                     overlap;
    logic                     counted;
    logic                     last_slot;
    logic                     invuln_active;

    // One comparator shared by all slots; sign-extended so the difference never wraps.
    always_comb begin
        ext_obst   = {bus.obst_voffset[idx][VWIDTH-1], bus.obst_voffset[idx]};
        ext_player = {snap_voffset[VWIDTH-1], snap_voffset};
        delta      = ext_obst - ext_player;
        delta_mag  = delta[DW-1] ? $unsigned(-delta) : $unsigned(delta);
        overlap    = bus.obst_valid[idx]
                     && (bus.obst_lane[idx] == snap_lane)
                     && (delta_mag <= DW'(HIT_WINDOW));
        last_slot  = (idx == SLOT_W'(NUM_OBST - 1));
        counted    = (state == S_SCAN) && overlap && !hit_flag[idx]
                     && (lives_q != '0) && !invuln_active;
    end

`ifdef COLLISION_INVULN_EN
    localparam int INV_W = $clog2(INVULN_FRAMES + 1);
    logic [INV_W-1:0] invuln_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            invuln_cnt <= '0;
        end else if (bus.restart) begin
            invuln_cnt <= '0;
        end else if (counted) begin
            invuln_cnt <= INV_W'(INVULN_FRAMES);
        end else if (bus.frame_tick && (invuln_cnt != '0)) begin
            invuln_cnt <= invuln_cnt - 1'b1;
        end
    end

    assign invuln_active = (invuln_cnt != '0);
`else
    assign invuln_active = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        bus.busy       = 1'b0;
        bus.sweep_done = 1'b0;
        bus.game_over  = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.frame_tick) begin
                    state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                bus.busy = 1'b1;
                if (last_slot) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                bus.sweep_done = 1'b1;
                state_nxt      = (lives_q == '0) ? S_OVER : S_IDLE;
            end
            S_OVER: begin
                bus.game_over = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (bus.restart) begin
            state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx          <= '0;
            snap_lane    <= '0;
            snap_voffset <= '0;
            hit_flag     <= '0;
            hit_pulse_q  <= 1'b0;
            hit_slot_q   <= '0;
            hit_count_q  <= '0;
            lives_q      <= LIFE_W'(START_LIVES);
        end else begin
            hit_pulse_q <= 1'b0;
            if (bus.restart) begin
                idx         <= '0;
                hit_flag    <= '0;
                hit_count_q <= '0;
                lives_q     <= LIFE_W'(START_LIVES);
            end else begin
                if ((state == S_IDLE) && bus.frame_tick) begin
                    snap_lane    <= bus.player_lane;
                    snap_voffset <= bus.player_voffset;
                    idx          <= '0;
                end
                if (state == S_SCAN) begin
                    idx           <= last_slot ? '0 : idx + 1'b1;
                    // Flag tracks continuous overlap so one obstacle counts once per pass.
                    hit_flag[idx] <= overlap;
                    if (counted) begin
                        hit_pulse_q <= 1'b1;
                        hit_slot_q  <= idx;
                        lives_q     <= lives_q - 1'b1;
                        if (hit_count_q != '1) begin
                            hit_count_q <= hit_count_q + 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign bus.hit_pulse = hit_pulse_q;
    assign bus.hit_slot  = hit_slot_q;
    assign bus.hit_count = hit_count_q;
    assign bus.lives     = lives_q;
endmodule

// File: doc/collision_sched.md
COLLISION_SCHED -- requirements
Module: collision_sched

Interface
REQ-001 NUM_OBST, 4: obstacle slots scanned per sweep; minimum 2.
REQ-002 VWIDTH, 12: signed vertical offset width.
REQ-003 LWIDTH, 2: lane index width.
REQ-004 COUNT_WIDTH, 32: hit_count width.
REQ-005 HIT_WINDOW, 5: maximum |obstacle voffset - player voffset| that counts as overlap.
REQ-006 START_LIVES, 3: lives loaded at reset and restart; minimum 1.
REQ-007 INVULN_FRAMES, 60: frame ticks of immunity after a counted hit (only with COLLISION_INVULN_EN).
REQ-008 clk  in  1  single system clock; all logic on rising edge.
REQ-009 rst_n  in  1  asynchronous, active-low reset.
REQ-010 frame_tick  in  1  one-cycle pulse; starts a sweep.
REQ-011 restart  in  1  synchronous new-game request.
REQ-012 player_lane  in  LWIDTH  player lane.
REQ-013 player_voffset  in  VWIDTH signed  player vertical position.
REQ-014 obst_valid  in  NUM_OBST  per-slot occupied flag.
REQ-015 obst_lane  in  LWIDTH x NUM_OBST (unpacked)  per-slot lane.
REQ-016 obst_voffset  in  VWIDTH signed x NUM_OBST (unpacked)  per-slot vertical position.
REQ-017 busy  out  1  high while SCAN is active.
REQ-018 sweep_done  out  1  one-cycle pulse at sweep end.
REQ-019 hit_pulse  out  1  one-cycle pulse per counted hit.
REQ-020 hit_slot  out  $clog2(NUM_OBST)  slot of latest counted hit; held until the next one.
REQ-021 hit_count  out  COUNT_WIDTH  total counted hits; saturates at all-ones.
REQ-022 lives  out  $clog2(START_LIVES+1)  remaining lives.
REQ-023 game_over  out  1  high in state OVER.

Function
REQ-024 FSM states: IDLE, SCAN, DONE, OVER.
REQ-025 IDLE + frame_tick: snapshot player_lane/player_voffset, set idx=0, go to SCAN.
REQ-026 SCAN: evaluate slot idx each cycle through one shared comparator; idx increments; after idx=NUM_OBST-1, go to DONE; a sweep occupies exactly NUM_OBST cycles.
REQ-027 DONE: sweep_done=1 for one cycle, then IDLE (or OVER if lives==0).
REQ-028 frame_tick in SCAN or DONE: ignored; no queuing.
REQ-029 Overlap: obst_valid[idx] && obst_lane[idx]==snapshot lane && |obst_voffset[idx]-snapshot voffset| <= HIT_WINDOW; subtraction at VWIDTH+1 bits, no wrap.
REQ-030 Each slot has a sticky hit flag; overlap with flag clear is a counted hit and sets flag; non-overlap clears flag; one obstacle counts at most once per pass.
REQ-031 Counted hit: at the next edge hit_pulse=1, hit_slot=idx, hit_count+1 (saturating), lives-1.
REQ-032 lives reaching 0: remainder of the sweep runs but counts no further hits; DONE then goes to OVER.
REQ-033 OVER: frame_tick ignored; busy=0; outputs hold.
REQ-034 restart (any state, priority over frame_tick): next cycle IDLE, hit_count=0, lives=START_LIVES, hit flags cleared, pulses 0.

Reset
REQ-035 rst_n low: state IDLE, idx=0, busy=0, sweep_done=0, hit_pulse=0, hit_slot=0, hit_count=0, lives=START_LIVES, game_over=0, hit flags cleared, invuln counter=0; reset mid-sweep aborts it.

Configuration
REQ-036 COLLISION_INVULN_EN defined: a counted hit loads a counter with INVULN_FRAMES; it decrements on each frame_tick while nonzero; while nonzero, overlaps set hit flags but produce no hit_pulse, count, or life loss.
REQ-037 COLLISION_INVULN_EN undefined: no counter; every qualifying overlap is counted.

Verification
REQ-038 Slot 2 lane 1 voffset 105, player lane 1 voffset 100, tick -> hit_pulse 3 cycles after tick, hit_slot=2, hit_count=1, lives=2.
REQ-039 Same obstacle held over 3 ticks -> only one hit; move it to voffset 200 for a tick, back to 100 -> second hit.
REQ-040 voffset 106 (delta 6), or lane mismatch, or obst_valid=0 -> no hit; delta -5 -> hit.
REQ-041 Three hits from START_LIVES=3 -> lives=0, game_over after DONE; further ticks ignored; restart -> lives=3, hit_count=0, IDLE.
REQ-042 frame_tick again 1 cycle into a sweep -> ignored; sweep_done exactly once.
REQ-043 With COLLISION_INVULN_EN: hit, then new overlap on the next tick -> no count until 60 ticks elapse; rst_n low mid-sweep -> all outputs at reset values.
